// File: rtl/enc_pkg.sv
// Shared types and quadrature lookup for the A/B encoder signal generator.
package enc_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int PHASE_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam logic [1:0] STEP0 = 2'd0;
    localparam logic [1:0] STEP1 = 2'd1;
    localparam logic [1:0] STEP2 = 2'd2;
    localparam logic [1:0] STEP3 = 2'd3;

    // Returns {A, B} for a given direction and step.
    function automatic logic [1:0] quad_ab(input logic dir, input logic [1:0] step);
        logic [1:0] ab;
        unique case (step)
            STEP0:   ab = 2'b00;
            STEP1:   ab = dir ? 2'b01 : 2'b10;
            STEP2:   ab = 2'b11;
            default: ab = dir ? 2'b10 : 2'b01;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_phase_timer.sv
// Phase timer: counts 0..len-1 while running and strobes tick at terminal count.
module enc_phase_timer #(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               run,
    input  logic [PHASE_W-1:0] len,
    output logic [PHASE_W-1:0] cnt,
    output logic               tick
);

    assign tick = run && (cnt == len - PHASE_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PHASE_W'(1);
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B burst generator; define GLITCH_INJECT_EN to add the
// single-cycle A glitch injector (glitch_req / glitch_cnt).
module quad_encoder_gen
    import enc_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               dir,
    input  logic [PHASE_W-1:0] phase_len,
    input  logic [CNT_W-1:0]   pulse_target,
`ifdef GLITCH_INJECT_EN
    input  logic               glitch_req,
    output logic [15:0]        glitch_cnt,
`endif
    output logic               enc_a,
    output logic               enc_b,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pulses_sent
);

    state_t             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic               dir_q;
    logic [PHASE_W-1:0] len_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_q, b_q, done_q, done_d;
    logic               latch, tick, fire;
    logic [1:0]         ab_now, ab_next, ab_out;
    logic [PHASE_W-1:0] phase_cnt;

    enc_phase_timer #(.PHASE_W(PHASE_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (latch),
        .run  (state_q != IDLE),
        .len  (len_q),
        .cnt  (phase_cnt),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        latch   = 1'b0;
        ab_now  = quad_ab(dir_q, step_q);
        ab_next = ab_now;
        unique case (state_q)
            IDLE: begin
                if (start && phase_len != '0) begin
                    latch   = 1'b1;
                    state_d = RUN;
                    step_d  = STEP0;
                    cnt_d   = '0;
                end
            end
            RUN, STOP: begin
                if (state_q == RUN && abort) state_d = STOP;
                if (tick) begin
                    // A cycle only ends after step3, so no partial pulse leaks out.
                    if (step_q == STEP3 &&
                        ((tgt_q != '0 && cnt_q == tgt_q) || state_d == STOP)) begin
                        state_d = IDLE;
                        step_d  = STEP0;
                        done_d  = 1'b1;
                    end else begin
                        step_d  = step_q + 2'd1;
                        ab_next = quad_ab(dir_q, step_d);
                        if (ab_next[1] && !ab_now[1]) cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ab_out = (state_d == IDLE) ? 2'b00 : quad_ab(dir_q, step_d);
    end

`ifdef GLITCH_INJECT_EN
    logic        armed_q, armed_d;
    logic [15:0] gcnt_q;

    // Fires on the cycle before phase counter 1 of step0, so the registered A shows it there.
    assign fire = armed_q && state_q != IDLE && state_d != IDLE &&
                  step_q == STEP0 && phase_cnt == '0 && len_q >= PHASE_W'(4);

    always_comb begin
        armed_d = (armed_q || (glitch_req && state_q != IDLE)) && !fire;
        if (state_d == IDLE) armed_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            armed_q <= armed_d;
            if (fire) gcnt_q <= gcnt_q + 16'd1;
        end
    end

    assign glitch_cnt = gcnt_q;
`else
    assign fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= STEP0;
            dir_q   <= 1'b0;
            len_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            a_q     <= ab_out[1] | fire;
            b_q     <= ab_out[0];
            done_q  <= done_d;
            if (latch) begin
                dir_q <= dir;
                len_q <= phase_len;
                tgt_q <= pulse_target;
            end
        end
    end

    assign enc_a       = a_q;
    assign enc_b       = b_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign pulses_sent = cnt_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Randomized scoreboard bench for quad_encoder_gen.
module tb_quad_encoder_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] phase_len = '0;
    logic [31:0] pulse_target = '0;
    logic        enc_a, enc_b, busy, done;
    logic [31:0] pulses_sent;
`ifdef GLITCH_INJECT_EN
    logic        glitch_req = 1'b0;
    logic [15:0] glitch_cnt;
`endif

    quad_encoder_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dir          (dir),
        .phase_len    (phase_len),
        .pulse_target (pulse_target),
`ifdef GLITCH_INJECT_EN
        .glitch_req   (glitch_req),
        .glitch_cnt   (glitch_cnt),
`endif
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .busy         (busy),
        .done         (done),
        .pulses_sent  (pulses_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int pulses;
        bit dir;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Pulses emitted: whole cycles through the one containing the abort, capped by the target.
    function automatic int model_pulses(input int len, input int tgt, input int k);
        int n_ab;
        n_ab = (k < 0) ? 32'h7fff_ffff : k / (4 * len) + 1;
        if (tgt == 0) return n_ab;
        return (n_ab < tgt) ? n_ab : tgt;
    endfunction

    // Monitor: pops one expectation per burst and checks edges and ending.
    exp_t cur;
    bit   in_burst = 0;
    bit   prev_a = 0, prev_b = 0;
    int   cyc = 0, a_rises = 0, b_rises = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_burst = 0;
            prev_a = 0;
            prev_b = 0;
        end else begin
            if (busy && !in_burst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_busy", 1, 0);
                    cur = '{1, 0, 1'b0};
                end else begin
                    cur = exp_q.pop_front();
                end
                in_burst = 1;
                cyc = 0;
                a_rises = 0;
                b_rises = 0;
            end
            if (in_burst && busy) begin
                if (enc_a && !prev_a) begin
                    check("a_rise_pos", cyc,
                          cur.len * (cur.dir ? 2 : 1) + 4 * cur.len * a_rises);
                    check("b_at_a_rise", enc_b, cur.dir);
                    a_rises++;
                    check("pulses_live", pulses_sent, a_rises);
                end
                if (enc_b && !prev_b) begin
                    check("b_rise_pos", cyc,
                          cur.len * (cur.dir ? 1 : 2) + 4 * cur.len * b_rises);
                    b_rises++;
                end
                cyc++;
            end
            if (done) begin
                if (!in_burst) begin
                    check("stray_done", 1, 0);
                end else begin
                    check("busy_cycles", cyc, 4 * cur.len * cur.pulses);
                    check("a_rise_count", a_rises, cur.pulses);
                    check("pulses_sent", pulses_sent, cur.pulses);
                    check("ab_idle", {enc_a, enc_b}, 0);
                    check("busy_low", busy, 0);
                end
                in_burst = 0;
            end
            prev_a = enc_a;
            prev_b = enc_b;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_burst(input int len, input int tgt, input bit d,
                             input int k, input bit abort_with_start);
        exp_t e;
        int   n, budget;
        bit   seen;
        n = model_pulses(len, tgt, abort_with_start ? -1 : k);
        e = '{len, n, d};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b1;
        dir = d;
        phase_len = 16'(len);
        pulse_target = 32'(tgt);
        abort = abort_with_start;
        budget = 4 * len * n + 10;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                start = 1'b0;
                abort = 1'b0;
            end else begin
                start = ($urandom_range(0, 7) == 0);
                abort = (c == k);
                dir = 1'($urandom);
                phase_len = 16'($urandom);
                pulse_target = 32'($urandom);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (!seen) begin
            check("burst_timeout", 0, 1);
            do_reset();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        exp_t e;
        int   len, tgt, k;
        do_reset();
        check("rst_a", enc_a, 0);
        check("rst_b", enc_b, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pulses", pulses_sent, 0);

        run_burst(4, 3, 1'b0, -1, 1'b0);
        run_burst(4, 3, 1'b1, -1, 1'b0);
        run_burst(2, 0, 1'b0, 11, 1'b0);

        // phase_len of zero must not start a burst
        @(posedge clk);
        #1 start = 1'b1;
        phase_len = '0;
        pulse_target = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
            check("zero_len_busy", busy, 0);
            check("zero_len_done", done, 0);
        end

        // abort while idle is ignored
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(posedge clk);
        #1 check("idle_abort_busy", busy, 0);

        run_burst(3, 2, 1'b1, -1, 1'b1);

        // reset in the middle of step2 of the first pulse
        e = '{4, 3, 1'b0};
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b1;
        dir = 1'b0;
        phase_len = 16'd4;
        pulse_target = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 check("pre_rst_pulses", pulses_sent, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("mid_rst_a", enc_a, 0);
        check("mid_rst_b", enc_b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pulses", pulses_sent, 0);
        rst = 1'b0;
        exp_q.delete();
        run_burst(4, 3, 1'b0, -1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(1, 6);
            tgt = $urandom_range(0, 4);
            if (tgt == 0) k = $urandom_range(0, 4 * len * 3);
            else if ($urandom_range(0, 2) == 0) k = $urandom_range(0, 4 * len * tgt + 2);
            else k = -1;
            run_burst(len, tgt, 1'($urandom), k, 1'b0);
        end

        repeat (4) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
